// File: rtl/dclock_pkg.sv
// Shared digital-clock definitions: mode encodings, time limits and the
// alarm ring FSM state type.
package dclock_pkg;

  localparam logic [1:0] M1_TIME  = 2'd0;
  localparam logic [1:0] M1_ALARM = 2'd1;

  localparam logic [1:0] M2_ALARM_G    = 2'd0;
  localparam logic [1:0] M2_ALARM_HOUR = 2'd1;
  localparam logic [1:0] M2_ALARM_MIN  = 2'd2;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } alarm_state_e;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: editable alarm time, armed flag, snooze target and the
// once-per-minute-entry match detector.
module alarm_channel
  import dclock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_hour_i,
  input  logic       inc_min_i,
  input  logic       toggle_arm_i,
  input  logic       snooze_load_i,
  input  logic       ignore_i,
  input  logic       time_chg_i,
  input  logic [4:0] hours_i,
  input  logic [5:0] mins_i,
  output logic       fire_o,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic       armed_o
);

  logic [4:0] hour_q, hour_d, snz_h_q, snz_h_d;
  logic [5:0] min_q, min_d, snz_m_q, snz_m_d;
  logic       armed_q, armed_d, snz_valid_q, snz_valid_d;
  logic       alarm_hit, snz_hit;
  logic [6:0] m_sum;

  assign alarm_hit = armed_q && (hour_q == hours_i) && (min_q == mins_i);
  assign snz_hit   = snz_valid_q && (snz_h_q == hours_i) && (snz_m_q == mins_i);
  assign fire_o    = time_chg_i && !ignore_i && (alarm_hit || snz_hit);
  assign m_sum     = {1'b0, mins_i} + 7'(SNOOZE_MIN);

  always_comb begin
    hour_d      = hour_q;
    min_d       = min_q;
    armed_d     = armed_q;
    snz_valid_d = snz_valid_q;
    snz_h_d     = snz_h_q;
    snz_m_d     = snz_m_q;
    if (inc_hour_i) hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
    if (inc_min_i)  min_d  = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
    if (fire_o) snz_valid_d = 1'b0;
    if (snooze_load_i) begin
      snz_valid_d = 1'b1;
      // Minute overflow carries into the hour, which itself wraps at midnight.
      if (m_sum > {1'b0, MIN_MAX}) begin
        snz_m_d = 6'(m_sum - 7'd60);
        snz_h_d = (hours_i == HOUR_MAX) ? 5'd0 : hours_i + 5'd1;
      end else begin
        snz_m_d = m_sum[5:0];
        snz_h_d = hours_i;
      end
    end
    if (toggle_arm_i) armed_d = ~armed_q;
    if (inc_hour_i || inc_min_i) begin
      armed_d     = 1'b1;
      snz_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_q      <= '0;
      min_q       <= '0;
      armed_q     <= 1'b0;
      snz_valid_q <= 1'b0;
      snz_h_q     <= '0;
      snz_m_q     <= '0;
    end else begin
      hour_q      <= hour_d;
      min_q       <= min_d;
      armed_q     <= armed_d;
      snz_valid_q <= snz_valid_d;
      snz_h_q     <= snz_h_d;
      snz_m_q     <= snz_m_d;
    end
  end

  assign hour_o  = hour_q;
  assign min_o   = min_q;
  assign armed_o = armed_q;

endmodule

// File: rtl/multi_alarm.sv
// Multi-channel alarm unit: channel selection/editing, pending vector,
// lowest-index arbitration and the IDLE/RING state machine with timeout.
module multi_alarm
  import dclock_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int IDX_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  increase,
  input  logic                  set,
  input  logic                  snooze,
  input  logic [1:0]            mode1,
  input  logic [1:0]            mode2,
  input  logic [4:0]            hours,
  input  logic [5:0]            mins,
  output logic [IDX_W-1:0]      sel_idx,
  output logic [4:0]            alarm_h,
  output logic [5:0]            alarm_m,
  output logic [NUM_ALARMS-1:0] armed,
  output logic                  alarm,
  output logic [IDX_W-1:0]      ring_idx
);

  alarm_state_e          state_q, state_d;
  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d, ring_idx_q, ring_idx_d, low_idx;
  logic [NUM_ALARMS-1:0] pending_q, pending_d, fire_vec, edit_clr, pend_clr, low_oh;
  logic [4:0]            prev_h_q;
  logic [5:0]            prev_m_q, tmo_q, tmo_d;
  logic                  in_alarm, sel_step, hour_step, min_step, arm_toggle;
  logic                  time_chg, min_chg, snz_load;
  logic [4:0]            ch_h [NUM_ALARMS];
  logic [5:0]            ch_m [NUM_ALARMS];

  assign in_alarm   = (mode1 == M1_ALARM);
  assign sel_step   = in_alarm && (mode2 == M2_ALARM_G) && increase;
  assign hour_step  = in_alarm && (mode2 == M2_ALARM_HOUR) && increase;
  assign min_step   = in_alarm && (mode2 == M2_ALARM_MIN) && increase;
  assign arm_toggle = in_alarm && (mode2 == M2_ALARM_G) && set && (state_q == IDLE);
  assign time_chg   = (hours != prev_h_q) || (mins != prev_m_q);
  assign min_chg    = (mins != prev_m_q);

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
      logic sel_hit;
      assign sel_hit      = (sel_idx_q == IDX_W'(gi));
      assign edit_clr[gi] = sel_hit && (hour_step || min_step);

      alarm_channel #(.SNOOZE_MIN(SNOOZE_MIN)) u_ch (
        .clk          (clk),
        .reset        (reset),
        .inc_hour_i   (hour_step && sel_hit),
        .inc_min_i    (min_step && sel_hit),
        .toggle_arm_i (arm_toggle && sel_hit),
        .snooze_load_i(snz_load && (ring_idx_q == IDX_W'(gi))),
        .ignore_i     ((state_q == RING) && (ring_idx_q == IDX_W'(gi))),
        .time_chg_i   (time_chg),
        .hours_i      (hours),
        .mins_i       (mins),
        .fire_o       (fire_vec[gi]),
        .hour_o       (ch_h[gi]),
        .min_o        (ch_m[gi]),
        .armed_o      (armed[gi])
      );
    end
  endgenerate

  // Lowest set bit wins: both as an index and as a one-hot clear mask.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end
  assign low_oh = pending_q & ~(pending_q - NUM_ALARMS'(1));

  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    tmo_d      = tmo_q;
    snz_load   = 1'b0;
    pend_clr   = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d    = RING;
          ring_idx_d = low_idx;
          pend_clr   = low_oh;
          tmo_d      = '0;
        end
      end
      RING: begin
        if (set) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d  = IDLE;
          snz_load = 1'b1;
        end else if (min_chg) begin
          if (tmo_q == 6'(RING_TIMEOUT_MIN - 1)) state_d = IDLE;
          else tmo_d = tmo_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_d = (pending_q & ~pend_clr & ~edit_clr) | fire_vec;
  assign sel_idx_d = !sel_step ? sel_idx_q :
                     (sel_idx_q == IDX_W'(NUM_ALARMS - 1)) ? '0 : sel_idx_q + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_idx_q  <= '0;
      ring_idx_q <= '0;
      pending_q  <= '0;
      tmo_q      <= '0;
      prev_h_q   <= '0;
      prev_m_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      ring_idx_q <= ring_idx_d;
      pending_q  <= pending_d;
      tmo_q      <= tmo_d;
      prev_h_q   <= hours;
      prev_m_q   <= mins;
    end
  end

  assign sel_idx  = sel_idx_q;
  assign alarm_h  = ch_h[sel_idx_q];
  assign alarm_m  = ch_m[sel_idx_q];
  assign alarm    = (state_q == RING);
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Self-checking bench for multi_alarm: table-driven edit vectors plus
// hand-written ring, snooze, timeout and reset sequences.
module tb_multi_alarm;
  import dclock_pkg::*;

  localparam int NA = 4;
  localparam int IW = 2;

  logic          clk = 1'b0, reset = 1'b1, increase = 1'b0, set = 1'b0, snooze = 1'b0;
  logic [1:0]    mode1 = M1_TIME, mode2 = M2_ALARM_G;
  logic [4:0]    hours = '0;
  logic [5:0]    mins = '0;
  logic [IW-1:0] sel_idx, ring_idx;
  logic [4:0]    alarm_h;
  logic [5:0]    alarm_m;
  logic [NA-1:0] armed;
  logic          alarm;

  multi_alarm #(.NUM_ALARMS(NA), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(10)) dut (
    .clk(clk), .reset(reset), .increase(increase), .set(set), .snooze(snooze),
    .mode1(mode1), .mode2(mode2), .hours(hours), .mins(mins),
    .sel_idx(sel_idx), .alarm_h(alarm_h), .alarm_m(alarm_m), .armed(armed),
    .alarm(alarm), .ring_idx(ring_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the user-visible state
  int            msel;
  int            mh [NA];
  int            mm [NA];
  logic [NA-1:0] marm;
  int            mring;

  typedef struct {
    string         name;
    logic          alarm;
    int            ring;
    int            sel;
    int            h;
    int            m;
    logic [NA-1:0] arm;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0]    m1;
    logic [1:0]    m2;
    int            reps;
    int            sel;
    int            h;
    int            m;
    logic [NA-1:0] arm;
  } vec_t;
  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    msel  = 0;
    marm  = '0;
    mring = 0;
    for (int i = 0; i < NA; i++) begin
      mh[i] = 0;
      mm[i] = 0;
    end
  endtask

  task automatic push_exp(string name, logic a);
    exp_t e;
    e.name  = name;
    e.alarm = a;
    e.ring  = mring;
    e.sel   = msel;
    e.h     = mh[msel];
    e.m     = mm[msel];
    e.arm   = marm;
    sb_q.push_back(e);
  endtask

  task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb_q.pop_front();
    cmp(e.name, "alarm", 32'(alarm), 32'(e.alarm));
    cmp(e.name, "ring_idx", 32'(ring_idx), 32'(e.ring));
    cmp(e.name, "sel_idx", 32'(sel_idx), 32'(e.sel));
    cmp(e.name, "alarm_h", 32'(alarm_h), 32'(e.h));
    cmp(e.name, "alarm_m", 32'(alarm_m), 32'(e.m));
    cmp(e.name, "armed", 32'(armed), 32'(e.arm));
    $display("obs %-14s time=%02d:%02d alarm=%0b ring=%0d sel=%0d alarm_t=%02d:%02d armed=%b",
             e.name, hours, mins, alarm, ring_idx, sel_idx, alarm_h, alarm_m, armed);
  endtask

  task automatic step(string name, logic a);
    push_exp(name, a);
    tick();
    pop_cmp();
  endtask

  task automatic edit(logic [1:0] m2, int n);
    mode1    = M1_ALARM;
    mode2    = m2;
    increase = 1'b1;
    repeat (n) begin
      tick();
      if (m2 == M2_ALARM_G) msel = (msel + 1) % NA;
      else if (m2 == M2_ALARM_HOUR) begin
        mh[msel]   = (mh[msel] + 1) % 24;
        marm[msel] = 1'b1;
      end else begin
        mm[msel]   = (mm[msel] + 1) % 60;
        marm[msel] = 1'b1;
      end
    end
    increase = 1'b0;
    mode1    = M1_TIME;
  endtask

  task automatic set_alarm(int ch, int h, int m);
    edit(M2_ALARM_G, (ch - msel + NA) % NA);
    edit(M2_ALARM_HOUR, (h - mh[ch] + 24) % 24);
    edit(M2_ALARM_MIN, (m - mm[ch] + 60) % 60);
    step($sformatf("set_ch%0d", ch), 1'b0);
  endtask

  task automatic toggle_arm();
    mode1      = M1_ALARM;
    mode2      = M2_ALARM_G;
    set        = 1'b1;
    marm[msel] = ~marm[msel];
    tick();
    set   = 1'b0;
    mode1 = M1_TIME;
  endtask

  task automatic enter(int h, int m, string name, logic a);
    hours = 5'(h);
    mins  = 6'(m);
    step(name, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vt[0]  = '{M1_ALARM, M2_ALARM_G,    1,  1,  0,  0, 4'b0000};
    vt[1]  = '{M1_ALARM, M2_ALARM_HOUR, 7,  1,  7,  0, 4'b0010};
    vt[2]  = '{M1_ALARM, M2_ALARM_MIN,  30, 1,  7,  30, 4'b0010};
    vt[3]  = '{M1_TIME,  M2_ALARM_MIN,  3,  1,  7,  30, 4'b0010};
    vt[4]  = '{M1_ALARM, M2_ALARM_G,    1,  2,  0,  0, 4'b0010};
    vt[5]  = '{M1_ALARM, M2_ALARM_G,    2,  0,  0,  0, 4'b0010};
    vt[6]  = '{M1_ALARM, M2_ALARM_HOUR, 23, 0,  23, 0, 4'b0011};
    vt[7]  = '{M1_ALARM, M2_ALARM_HOUR, 1,  0,  0,  0, 4'b0011};
    vt[8]  = '{M1_ALARM, M2_ALARM_MIN,  59, 0,  0,  59, 4'b0011};
    vt[9]  = '{M1_ALARM, M2_ALARM_MIN,  1,  0,  0,  0, 4'b0011};
    vt[10] = '{M1_ALARM, M2_ALARM_G,    1,  1,  7,  30, 4'b0011};

    model_reset();
    repeat (2) tick();
    push_exp("reset_state", 1'b0);
    pop_cmp();
    reset = 1'b0;
    step("post_reset", 1'b0);

    // Editing vectors: selection wrap, hour/minute wrap, no edit outside alarm mode
    foreach (vt[i]) begin
      if (vt[i].m1 == M1_ALARM) edit(vt[i].m2, vt[i].reps);
      else begin
        mode1    = vt[i].m1;
        mode2    = vt[i].m2;
        increase = 1'b1;
        repeat (vt[i].reps) tick();
        increase = 1'b0;
      end
      e.name  = $sformatf("vec%0d", i);
      e.alarm = 1'b0;
      e.ring  = mring;
      e.sel   = vt[i].sel;
      e.h     = vt[i].h;
      e.m     = vt[i].m;
      e.arm   = vt[i].arm;
      sb_q.push_back(e);
      tick();
      pop_cmp();
    end

    // Channel 1 at 07:30: latency, dismiss, no retrigger in the same minute
    enter(7, 29, "t1_0729", 1'b0);
    enter(7, 30, "t1_trig", 1'b0);
    mring = 1;
    step("t1_ring", 1'b1);
    set = 1'b1;
    step("t1_dismiss", 1'b0);
    set = 1'b0;
    repeat (4) step("t1_hold", 1'b0);

    // Channels 0 and 2 at 12:00 ring in ascending order with a one-cycle gap
    set_alarm(0, 12, 0);
    set_alarm(2, 12, 0);
    enter(11, 59, "t2_1159", 1'b0);
    enter(12, 0, "t2_trig", 1'b0);
    mring = 0;
    step("t2_ring0", 1'b1);
    set = 1'b1;
    step("t2_dismiss0", 1'b0);
    set = 1'b0;
    mring = 2;
    step("t2_ring2", 1'b1);
    set = 1'b1;
    step("t2_dismiss2", 1'b0);
    set = 1'b0;
    step("t2_idle", 1'b0);

    // Snooze across midnight: 23:58 + 5 -> 00:03
    set_alarm(3, 23, 58);
    enter(23, 57, "t3_2357", 1'b0);
    enter(23, 58, "t3_trig", 1'b0);
    mring = 3;
    step("t3_ring", 1'b1);
    snooze = 1'b1;
    step("t3_snooze", 1'b0);
    snooze = 1'b0;
    enter(23, 59, "t3_2359", 1'b0);
    for (int k = 0; k < 3; k++) enter(0, k, "t3_wait", 1'b0);
    enter(0, 3, "t3_snz_trig", 1'b0);
    step("t3_resnooze", 1'b1);
    set = 1'b1;
    step("t3_dismiss", 1'b0);
    set = 1'b0;

    // Unanswered ring stops on the 10th minute change
    enter(7, 29, "t4_0729", 1'b0);
    enter(7, 30, "t4_trig", 1'b0);
    mring = 1;
    step("t4_ring", 1'b1);
    for (int k = 31; k < 40; k++) enter(7, k, "t4_ringing", 1'b1);
    enter(7, 40, "t4_timeout", 1'b0);
    step("t4_after", 1'b0);

    // set and snooze together: dismiss wins, nothing at +5 minutes
    enter(7, 29, "t5_0729", 1'b0);
    enter(7, 30, "t5_trig", 1'b0);
    step("t5_ring", 1'b1);
    set    = 1'b1;
    snooze = 1'b1;
    step("t5_both", 1'b0);
    set    = 1'b0;
    snooze = 1'b0;
    for (int k = 31; k < 37; k++) enter(7, k, "t5_nosnooze", 1'b0);

    // Asynchronous reset while ringing
    enter(7, 29, "t6_0729", 1'b0);
    enter(7, 30, "t6_trig", 1'b0);
    step("t6_ring", 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    push_exp("t6_async_rst", 1'b0);
    pop_cmp();
    tick();
    reset = 1'b0;
    for (int k = 0; k < NA; k++) begin
      step($sformatf("t6_rd_ch%0d", k), 1'b0);
      edit(M2_ALARM_G, 1);
    end
    step("t6_sel_wrap", 1'b0);

    // Disarmed channel does not ring; re-arm by toggling again
    set_alarm(0, 1, 0);
    toggle_arm();
    step("t7_disarmed", 1'b0);
    enter(0, 59, "t7_0059", 1'b0);
    enter(1, 0, "t7_0100", 1'b0);
    repeat (2) step("t7_silent", 1'b0);
    toggle_arm();
    step("t7_rearmed", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm.md
# multi_alarm

Parametrised multi-channel alarm unit for the digital clock, the successor of the single-alarm set block. It holds NUM_ALARMS independently editable and armable alarm times, detects each time match once per minute, arbitrates between simultaneous alarms, and supports dismiss, snooze and automatic ring timeout. It sits beside the time counter and feeds the display selector with the currently selected alarm time.

## Interface
Parameters:
- NUM_ALARMS, 4: number of alarm channels, 1..8.
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.
- RING_TIMEOUT_MIN, 10: minute boundaries after which an unanswered ring stops, 1..59.
- IDX_W, max(1, clog2(NUM_ALARMS)): derived channel-index width.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- increase  in  1  level; one edit step per clk while high.
- set  in  1  level; dismiss while ringing, otherwise arm/disarm toggle.
- snooze  in  1  level; snooze the ringing channel.
- mode1, mode2  in  2 each  clock mode (package encodings).
- hours  in  5  current time, 0..23.
- mins  in  6  current time, 0..59.
- sel_idx  out  IDX_W  channel being viewed/edited.
- alarm_h  out  5  hour of the selected channel.
- alarm_m  out  6  minute of the selected channel.
- armed  out  NUM_ALARMS  per-channel armed flags.
- alarm  out  1  ring output.
- ring_idx  out  IDX_W  channel currently ringing (valid when alarm=1).

## Operation
- Reset values: all channel times 00:00; armed, pending and snooze-valid all 0; sel_idx 0; alarm 0; ring_idx 0; FSM in IDLE; minute-timeout counter 0.
- Editing (mode1 == M1_ALARM only):
  - mode2 == M2_ALARM_G with increase: sel_idx += 1, wrapping NUM_ALARMS-1 -> 0.
  - M2_ALARM_HOUR with increase: hour of the selected channel += 1, 23 -> 0.
  - M2_ALARM_MIN with increase: minute of the selected channel += 1, 59 -> 0.
  - Any HOUR or MIN edit cycle sets armed[sel] and clears that channel's pending and snooze-valid.
  - M2_ALARM_G with set, while alarm=0: toggles armed[sel].
- Trigger: channel i fires in the cycle where its target equals the current (hours, mins) and the current (hours, mins) differs from the value registered one cycle earlier. Each match therefore fires once per minute entry, and a dismiss never retriggers within the same minute.
  - The target is the alarm time when armed[i]=1.
  - The target is the snooze time when snz_valid[i]=1; snz_valid[i] clears on fire.
  - A fire sets pending[i].
- FSM:
  - IDLE -> RING when pending != 0. The lowest pending index is loaded into ring_idx, that pending bit clears, and the timeout counter is zeroed.
  - RING + set -> IDLE (dismiss).
  - RING + snooze (set=0) -> IDLE. snz_valid[ring_idx] is set, with target = current time + SNOOZE_MIN, minutes mod 60 carrying into hours mod 24.
  - RING: the timeout counter increments on each minute change. When it reaches RING_TIMEOUT_MIN, the FSM returns to IDLE as a dismiss.
  - Disarming the ringing channel does not stop the ring.
- alarm = 1 exactly in RING.

## Timing
- All outputs are registered. alarm_h, alarm_m and armed reflect an edit on the clk edge following the edit cycle.
- A trigger condition sampled at edge T gives alarm=1 after edge T+1; ring_idx is valid in the same cycle.
- A dismiss or snooze sampled at edge T gives alarm=0 after T. If pending != 0, the next ring starts after T+1, so there is a minimum one-cycle gap.
- Simultaneous events:
  - set and snooze together: set wins.
  - Fires on several channels in one cycle: all are recorded, and they ring in ascending index order.
  - A fire during RING is recorded and served after the current ring ends.
  - A fire on the currently ringing channel is ignored.
- Asynchronous reset mid-ring drops alarm to 0 immediately and clears all pending and snooze state.

## Structure
- Shared package dclock_pkg holds the M1_*/M2_* encodings, HOUR_MAX=23, MIN_MAX=59, and the FSM state typedef (IDLE, RING).
- Sub-module alarm_channel, instantiated NUM_ALARMS times, holds:
  - the time registers and wrap increments;
  - the armed flag;
  - the snooze target with its mod-60/mod-24 adder;
  - the fire output.
- The previous-time register is shared, in the top level.
- Top level: selection, lowest-index priority arbiter, pending vector, FSM, timeout counter.

## Test plan
- After reset, set channel 1 to 07:30 via M2_ALARM_G/HOUR/MIN, then advance the time 07:29 -> 07:30 -> alarm=1 and ring_idx=1 after the next edge; set -> alarm=0; holding 07:30 produces no retrigger.
- Channels 0 and 2 both at 12:00, enter 12:00 -> channel 0 rings first; set -> one idle cycle, then channel 2 rings; set -> alarm=0.
- Ring at 23:58, snooze with SNOOZE_MIN=5 -> alarm=0; ring resumes on entering 00:03 with the same ring_idx.
- Ring with no response, RING_TIMEOUT_MIN=10 -> alarm falls after the 10th minute change; armed is unchanged.
- Assert set and snooze together while ringing -> dismiss, with no snooze at +SNOOZE_MIN; assert reset mid-ring -> alarm=0 asynchronously and all times read 00:00.
- Toggle armed[0] off with set in M2_ALARM_G, then reach its time -> no ring; sel_idx wraps 3 -> 0 with NUM_ALARMS=4.
